// File: rtl/stopwatch_bcd_pkg.sv
// Shared constants for the centisecond stopwatch: state encoding,
// BCD digit width and per-digit terminal values.
package stopwatch_bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX9 = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX5 = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } state_t;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD counter digit that wraps at MAX and reports a carry when it wraps,
// so several instances can be chained into a ripple-carry counter.
module bcd_digit
  import stopwatch_bcd_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = BCD_MAX9
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               clr,
  input  logic               en,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  // clr takes precedence over en so a clear coinciding with a tick yields zero
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= (q == MAX) ? '0 : q + 4'd1;
  end

  assign carry = en & (q == MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.cc stopwatch: six chained BCD digits, a run/stop/lap FSM and a
// display register that freezes while in LAP.
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter bit ROLLOVER     = 1'b1,
  parameter int MAX_MIN_TENS = 5
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               tick,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               lap,
  output logic [DIGIT_W-1:0] cs_ones,
  output logic [DIGIT_W-1:0] cs_tens,
  output logic [DIGIT_W-1:0] s_ones,
  output logic [DIGIT_W-1:0] s_tens,
  output logic [DIGIT_W-1:0] m_ones,
  output logic [DIGIT_W-1:0] m_tens,
  output logic               running,
  output logic               overflow
);

  localparam logic [DIGIT_W-1:0] MT_MAX = DIGIT_W'(MAX_MIN_TENS);

  state_t state, state_next;

  logic [DIGIT_W-1:0] c_cso, c_cst, c_so, c_st, c_mo, c_mt;
  logic               k_cso, k_cst, k_so, k_st, k_mo, k_mt;
  logic               counting, at_terminal, sat_hit, cnt_en;
  logic [6*DIGIT_W-1:0] disp;

  assign counting    = (state == ST_RUN) || (state == ST_LAP);
  assign at_terminal = (c_cso == BCD_MAX9) && (c_cst == BCD_MAX9) &&
                       (c_so == BCD_MAX9) && (c_st == BCD_MAX5) &&
                       (c_mo == BCD_MAX9) && (c_mt == MT_MAX);
  // In saturating mode the terminal tick is swallowed and the FSM stops instead
  assign sat_hit     = !ROLLOVER && tick && counting && at_terminal;
  assign cnt_en      = tick && counting && !sat_hit;

  bcd_digit #(.MAX(BCD_MAX9)) u_cso (.Clock(Clock), .Resetn(Resetn), .clr(clear), .en(cnt_en), .q(c_cso), .carry(k_cso));
  bcd_digit #(.MAX(BCD_MAX9)) u_cst (.Clock(Clock), .Resetn(Resetn), .clr(clear), .en(k_cso),  .q(c_cst), .carry(k_cst));
  bcd_digit #(.MAX(BCD_MAX9)) u_so  (.Clock(Clock), .Resetn(Resetn), .clr(clear), .en(k_cst),  .q(c_so),  .carry(k_so));
  bcd_digit #(.MAX(BCD_MAX5)) u_st  (.Clock(Clock), .Resetn(Resetn), .clr(clear), .en(k_so),   .q(c_st),  .carry(k_st));
  bcd_digit #(.MAX(BCD_MAX9)) u_mo  (.Clock(Clock), .Resetn(Resetn), .clr(clear), .en(k_st),   .q(c_mo),  .carry(k_mo));
  bcd_digit #(.MAX(MT_MAX))   u_mt  (.Clock(Clock), .Resetn(Resetn), .clr(clear), .en(k_mo),   .q(c_mt),  .carry(k_mt));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear)
      state_next = ST_IDLE;
    else if (start_stop) begin
      case (state)
        ST_IDLE, ST_STOP: state_next = ST_RUN;
        ST_RUN, ST_LAP:   state_next = ST_STOP;
        default:          state_next = ST_IDLE;
      endcase
    end else if (sat_hit)
      state_next = ST_STOP;
    else if (lap) begin
      if (state == ST_RUN)
        state_next = ST_LAP;
      else if (state == ST_LAP)
        state_next = ST_RUN;
    end
  end

  // Display copies the pre-edge count, so entering LAP freezes the value
  // shown just before the lap pulse
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= ROLLOVER && k_mt && !clear;
      if (clear)
        disp <= '0;
      else if (state != ST_LAP)
        disp <= {c_mt, c_mo, c_st, c_so, c_cst, c_cso};
    end
  end

  assign {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} = disp;
  assign running = counting;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed self-checking bench: a default stopwatch plus two one-range-digit
// variants (wrapping and saturating) driven by the same inputs.
module tb_stopwatch_bcd;

  logic Clock = 1'b0;
  logic Resetn, tick, start_stop, clear, lap;

  logic [3:0] cso, cst, so, st, mo, mt;
  logic       run, ovf;
  logic [3:0] r_cso, r_cst, r_so, r_st, r_mo, r_mt;
  logic       r_run, r_ovf;
  logic [3:0] s_cso, s_cst, s_so, s_st, s_mo, s_mt;
  logic       s_run, s_ovf;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  stopwatch_bcd dut (
    .Clock(Clock), .Resetn(Resetn), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .cs_ones(cso), .cs_tens(cst), .s_ones(so),
    .s_tens(st), .m_ones(mo), .m_tens(mt), .running(run), .overflow(ovf)
  );

  stopwatch_bcd #(.ROLLOVER(1'b1), .MAX_MIN_TENS(0)) dut_r (
    .Clock(Clock), .Resetn(Resetn), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .cs_ones(r_cso), .cs_tens(r_cst), .s_ones(r_so),
    .s_tens(r_st), .m_ones(r_mo), .m_tens(r_mt), .running(r_run), .overflow(r_ovf)
  );

  stopwatch_bcd #(.ROLLOVER(1'b0), .MAX_MIN_TENS(0)) dut_s (
    .Clock(Clock), .Resetn(Resetn), .tick(tick), .start_stop(start_stop),
    .clear(clear), .lap(lap), .cs_ones(s_cso), .cs_tens(s_cst), .s_ones(s_so),
    .s_tens(s_st), .m_ones(s_mo), .m_tens(s_mt), .running(s_run), .overflow(s_ovf)
  );

  // Drive one cycle of controls, then return 1 time unit after the edge
  task automatic applyStimulus(input logic t, input logic ss, input logic cl, input logic lp);
    tick = t; start_stop = ss; clear = cl; lap = lp;
    @(posedge Clock);
    #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  function automatic logic [23:0] mainDigits();
    return {mt, mo, st, so, cst, cso};
  endfunction

  initial begin
    Resetn = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    repeat (2) @(posedge Clock);
    #3 Resetn = 1'b1;
    @(posedge Clock); #1;
    checkOutput("reset_digits", mainDigits(), 24'h000000);
    checkBit("reset_running", run, 1'b0);
    checkBit("reset_overflow", ovf, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("100_ticks", mainDigits(), 24'h000100);
    checkBit("100_ticks_running", run, 1'b1);
    ticks(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("101_ticks", mainDigits(), 24'h000101);

    ticks(5898);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("at_00_59_99", mainDigits(), 24'h005999);
    ticks(1);
    checkBit("no_overflow_minute", ovf, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("to_01_00_00", mainDigits(), 24'h010000);

    ticks(53999);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("at_09_59_99", mainDigits(), 24'h095999);
    checkOutput("wrap_at_terminal", {r_mt, r_mo, r_st, r_so, r_cst, r_cso}, 24'h095999);
    checkOutput("sat_at_terminal", {s_mt, s_mo, s_st, s_so, s_cst, s_cso}, 24'h095999);
    ticks(1);
    checkBit("wrap_overflow_pulse", r_ovf, 1'b1);
    checkBit("sat_stopped", s_run, 1'b0);
    checkBit("sat_no_overflow", s_ovf, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("to_10_00_00", mainDigits(), 24'h100000);
    checkBit("wrap_overflow_cleared", r_ovf, 1'b0);
    checkOutput("wrap_zero", {r_mt, r_mo, r_st, r_so, r_cst, r_cso}, 24'h000000);
    checkBit("wrap_still_running", r_run, 1'b1);
    checkOutput("sat_hold", {s_mt, s_mo, s_st, s_so, s_cst, s_cso}, 24'h095999);
    ticks(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_hold_after_tick", {s_mt, s_mo, s_st, s_so, s_cst, s_cso}, 24'h095999);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clear_digits", mainDigits(), 24'h000000);
    checkBit("clear_running", run, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_lap", mainDigits(), 24'h000005);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(30);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lap_frozen", mainDigits(), 24'h000005);
    checkBit("lap_running", run, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lap_release", mainDigits(), 24'h000035);

    ticks(1199);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("at_00_12_34", mainDigits(), 24'h001234);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("clear_with_tick", mainDigits(), 24'h000000);
    checkBit("clear_with_tick_idle", run, 1'b0);
    ticks(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_ignores_ticks", mainDigits(), 24'h000000);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(20107);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("at_03_21_07", mainDigits(), 24'h032107);
    #2 Resetn = 1'b0;
    #1;
    checkOutput("async_reset_digits", mainDigits(), 24'h000000);
    checkBit("async_reset_running", run, 1'b0);
    #1 Resetn = 1'b1;
    @(posedge Clock); #1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_reset_one_tick", mainDigits(), 24'h000001);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("run_tick_and_stop", mainDigits(), 24'h000002);
    checkBit("run_tick_and_stop_state", run, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stop_tick_and_start", mainDigits(), 24'h000002);
    checkBit("stop_tick_and_start_state", run, 1'b1);
    ticks(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_count", mainDigits(), 24'h000003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
